// File: rtl/gsensor_spi_pkg.sv
// Shared constants, state encoding and helpers for the G-sensor SPI responder.
package gsensor_spi_pkg;

  localparam int unsigned REG_ADDR_W = 6;
  localparam int unsigned BYTE_W     = 8;

  // Register map
  localparam logic [REG_ADDR_W-1:0] ADDR_DEVID       = 6'h00;
  localparam logic [REG_ADDR_W-1:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [REG_ADDR_W-1:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [REG_ADDR_W-1:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [REG_ADDR_W-1:0] ADDR_DATAX0      = 6'h32;
  localparam logic [REG_ADDR_W-1:0] ADDR_DATAX1      = 6'h33;
  localparam logic [REG_ADDR_W-1:0] ADDR_DATAY0      = 6'h34;
  localparam logic [REG_ADDR_W-1:0] ADDR_DATAY1      = 6'h35;
  localparam logic [REG_ADDR_W-1:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [REG_ADDR_W-1:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [BYTE_W-1:0] DEVID_DEFAULT = 8'hE5;

  // Command byte layout: R/W, multi-byte, start address
  localparam int unsigned CMD_RW_BIT = 7;
  localparam int unsigned CMD_MB_BIT = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  // DEVID and the axis data bytes cannot be written over SPI
  function automatic logic is_read_only(input logic [REG_ADDR_W-1:0] a);
    return (a == ADDR_DEVID) || ((a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1));
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one SPI pin with rise/fall pulses.
// The chain is intentionally not reset: a CSN held low across reset
// must not look like a fresh falling edge once reset is released.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic sync,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  // Shift the pin through the synchronizer, then keep one extra flop for edge detection
  always_ff @(posedge clk) begin
    stages[0] <= din;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      stages[i] <= stages[i-1];
    end
    prev <= stages[SYNC_STAGES-1];
  end

  assign sync   = stages[SYNC_STAGES-1];
  assign rise_c = sync & ~prev;
  assign fall_c = ~sync & prev;

endmodule

// File: rtl/gsensor_spi_responder.sv
// 3-wire SPI (mode 3) responder emulating an ADXL345-style accelerometer.
// Everything runs on iCLK; SCLK/CSN/SDIO are oversampled and edge-detected.
module gsensor_spi_responder
  import gsensor_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID       = 8'hE5,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSPI_CSN,
  input  logic              iSPI_CLK,
  input  logic              iSDIO,
  output logic              oSDIO,
  output logic              oSDIO_OE,
  input  logic [15:0]       iDATA_X,
  input  logic [15:0]       iDATA_Y,
  input  logic [15:0]       iDATA_Z,
  output logic              oWR_STB,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [7:0]        oWR_DATA
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic csn_sync, csn_rise_c, csn_fall_c;
  logic sclk_sync, sclk_rise_c, sclk_fall_c;
  logic sdio_sync, sdio_rise_c, sdio_fall_c;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
    .clk(iCLK), .din(iSPI_CSN), .sync(csn_sync), .rise_c(csn_rise_c), .fall_c(csn_fall_c)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(iCLK), .din(iSPI_CLK), .sync(sclk_sync), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdio (
    .clk(iCLK), .din(iSDIO), .sync(sdio_sync), .rise_c(sdio_rise_c), .fall_c(sdio_fall_c)
  );

  // Only the level of SDIO and the edges of SCLK/CSN are used
  logic unused_sync;
  assign unused_sync = ^{sclk_sync, sdio_rise_c, sdio_fall_c, csn_sync};

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [6:0]        shreg;
  logic [7:0]        rd_shift;
  logic [ADDR_W-1:0] addr;
  logic              mb;
  logic [15:0]       snap_x, snap_y, snap_z;
  logic [7:0]        regs [NREGS];

  logic [7:0]        rx_byte_c;
  logic [ADDR_W-1:0] next_addr_c;
  logic [ADDR_W-1:0] cmd_addr_c;
  logic              sclk_rise_act_c;
  logic              sclk_fall_act_c;

  // Byte completed by the current rise, and the address the frame moves to after it
  assign rx_byte_c       = {shreg, sdio_sync};
  assign cmd_addr_c      = ADDR_W'(rx_byte_c[REG_ADDR_W-1:0]);
  assign next_addr_c     = mb ? addr + ADDR_W'(1) : addr;
  assign sclk_rise_act_c = sclk_rise_c && (state != ST_IDLE);
  assign sclk_fall_act_c = sclk_fall_c && (state == ST_RDATA);

  // Register map read mux: DEVID, frame snapshot, or storage
  function automatic logic [7:0] reg_read(input logic [ADDR_W-1:0] a);
    logic [REG_ADDR_W-1:0] ra;
    ra = REG_ADDR_W'(a);
    case (ra)
      ADDR_DEVID:  reg_read = DEVID;
      ADDR_DATAX0: reg_read = snap_x[7:0];
      ADDR_DATAX1: reg_read = snap_x[15:8];
      ADDR_DATAY0: reg_read = snap_y[7:0];
      ADDR_DATAY1: reg_read = snap_y[15:8];
      ADDR_DATAZ0: reg_read = snap_z[7:0];
      ADDR_DATAZ1: reg_read = snap_z[15:8];
      default:     reg_read = regs[a];
    endcase
  endfunction

  // Frame state machine, register file and registered SDIO/strobe outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= 7'd0;
      rd_shift <= 8'hFF;
      addr     <= '0;
      mb       <= 1'b0;
      snap_x   <= 16'd0;
      snap_y   <= 16'd0;
      snap_z   <= 16'd0;
      oSDIO    <= 1'b1;
      oSDIO_OE <= 1'b0;
      oWR_STB  <= 1'b0;
      oWR_ADDR <= '0;
      oWR_DATA <= 8'd0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= 8'd0;
      end
    end else begin
      oWR_STB <= 1'b0;

      // Sample on SCLK rise; act on each completed byte
      if (sclk_rise_act_c) begin
        shreg   <= rx_byte_c[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          case (state)
            ST_CMD: begin
              mb   <= rx_byte_c[CMD_MB_BIT];
              addr <= cmd_addr_c;
              if (rx_byte_c[CMD_RW_BIT]) begin
                state    <= ST_RDATA;
                rd_shift <= reg_read(cmd_addr_c);
              end else begin
                state <= ST_WDATA;
              end
            end
            ST_WDATA: begin
              if (!is_read_only(REG_ADDR_W'(addr))) begin
                regs[addr] <= rx_byte_c;
                oWR_STB    <= 1'b1;
                oWR_ADDR   <= addr;
                oWR_DATA   <= rx_byte_c;
              end
              addr <= next_addr_c;
            end
            ST_RDATA: begin
              addr     <= next_addr_c;
              rd_shift <= reg_read(next_addr_c);
            end
            default: ;
          endcase
        end
      end

      // Drive the next read bit on SCLK fall
      if (sclk_fall_act_c) begin
        oSDIO_OE <= 1'b1;
        oSDIO    <= rd_shift[7];
        rd_shift <= {rd_shift[6:0], 1'b1};
      end

      // CSN edges override the frame state; a byte completing this cycle still commits
      if (csn_fall_c) begin
        state    <= ST_CMD;
        bit_cnt  <= 3'd0;
        snap_x   <= iDATA_X;
        snap_y   <= iDATA_Y;
        snap_z   <= iDATA_Z;
        oSDIO_OE <= 1'b0;
        oSDIO    <= 1'b1;
      end else if (csn_rise_c) begin
        state    <= ST_IDLE;
        bit_cnt  <= 3'd0;
        oSDIO_OE <= 1'b0;
        oSDIO    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Directed bench for gsensor_spi_responder: a mode-3 SPI initiator model
// drives frames; read bytes and write strobes are compared to fixed values.
module tb_gsensor_spi_responder;

  localparam int HALF = 13;  // SCLK half period in iCLK cycles (~1.9 MHz)

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iSPI_CSN = 1'b1;
  logic        iSPI_CLK = 1'b1;
  logic        iSDIO = 1'b1;
  logic        oSDIO;
  logic        oSDIO_OE;
  logic [15:0] iDATA_X = 16'd0;
  logic [15:0] iDATA_Y = 16'd0;
  logic [15:0] iDATA_Z = 16'd0;
  logic        oWR_STB;
  logic [5:0]  oWR_ADDR;
  logic [7:0]  oWR_DATA;

  gsensor_spi_responder dut (
    .iCLK(iCLK), .iRST(iRST), .iSPI_CSN(iSPI_CSN), .iSPI_CLK(iSPI_CLK),
    .iSDIO(iSDIO), .oSDIO(oSDIO), .oSDIO_OE(oSDIO_OE),
    .iDATA_X(iDATA_X), .iDATA_Y(iDATA_Y), .iDATA_Z(iDATA_Z),
    .oWR_STB(oWR_STB), .oWR_ADDR(oWR_ADDR), .oWR_DATA(oWR_DATA)
  );

  always #10 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Log every cycle with the strobe high
  int         stb_total = 0;
  logic [5:0] log_addr [16];
  logic [7:0] log_data [16];
  always @(negedge iCLK) begin
    if (oWR_STB) begin
      log_addr[stb_total % 16] = oWR_ADDR;
      log_data[stb_total % 16] = oWR_DATA;
      stb_total++;
    end
  end

  int oe_hits;  // SDIO driven while it should not be

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit watch_oe,
                          output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      @(negedge iCLK);
      iSPI_CLK = 1'b0;
      iSDIO    = tx[i];
      repeat (HALF) @(negedge iCLK);
      rx[i] = oSDIO_OE ? oSDIO : 1'b1;
      if (watch_oe && oSDIO_OE) oe_hits++;
      iSPI_CLK = 1'b1;
      repeat (HALF - 1) @(negedge iCLK);
    end
  endtask

  task automatic csn_low();
    @(negedge iCLK);
    iSPI_CSN = 1'b0;
    repeat (HALF) @(negedge iCLK);
  endtask

  task automatic csn_high();
    repeat (HALF) @(negedge iCLK);
    iSPI_CSN = 1'b1;
    iSDIO    = 1'b1;
    repeat (2 * HALF) @(negedge iCLK);
  endtask

  task automatic read1(input logic [7:0] cmd, output logic [7:0] data);
    logic [7:0] dummy;
    csn_low();
    spi_bits(cmd, 8, 1'b1, dummy);
    spi_bits(8'hFF, 8, 1'b0, data);
    csn_high();
  endtask

  task automatic write_bytes(input logic [7:0] cmd, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2, input int n);
    logic [7:0] dummy;
    csn_low();
    spi_bits(cmd, 8, 1'b1, dummy);
    spi_bits(b0, 8, 1'b1, dummy);
    if (n > 1) spi_bits(b1, 8, 1'b1, dummy);
    if (n > 2) spi_bits(b2, 8, 1'b1, dummy);
    csn_high();
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] dummy;
    logic [7:0] mbuf [6];
    int         base;

    // Reset values
    repeat (5) @(negedge iCLK);
    check("rst_sdio", 32'(oSDIO), 32'h1);
    check("rst_oe", 32'(oSDIO_OE), 32'h0);
    check("rst_stb", 32'(oWR_STB), 32'h0);
    check("rst_addr", 32'(oWR_ADDR), 32'h0);
    check("rst_data", 32'(oWR_DATA), 32'h0);
    iRST = 1'b0;
    repeat (5) @(negedge iCLK);

    // 1: DEVID read
    base = stb_total;
    oe_hits = 0;
    read1(8'h80, rd);
    check("devid", 32'(rd), 32'hE5);
    check("devid_oe_cmd", 32'(oe_hits), 32'h0);
    check("devid_oe_after", 32'(oSDIO_OE), 32'h0);
    check("devid_no_stb", 32'(stb_total - base), 32'h0);

    // 2: write 0x2D=0x08, read back
    base = stb_total;
    write_bytes(8'h2D, 8'h08, 8'h00, 8'h00, 1);
    check("wr_stb_cnt", 32'(stb_total - base), 32'h1);
    check("wr_stb_addr", 32'(log_addr[base % 16]), 32'h2D);
    check("wr_stb_data", 32'(log_data[base % 16]), 32'h08);
    read1(8'hAD, rd);
    check("rd_2d", 32'(rd), 32'h08);

    // 3: coherent multi-byte snapshot read
    iDATA_X = 16'h1234;
    iDATA_Y = 16'hFF80;
    iDATA_Z = 16'h0100;
    csn_low();
    spi_bits(8'hF2, 8, 1'b0, dummy);
    for (int b = 0; b < 6; b++) begin
      spi_bits(8'hFF, 8, 1'b0, mbuf[b]);
      if (b == 1) iDATA_X = 16'hAAAA;
    end
    csn_high();
    check("snap_x0", 32'(mbuf[0]), 32'h34);
    check("snap_x1", 32'(mbuf[1]), 32'h12);
    check("snap_y0", 32'(mbuf[2]), 32'h80);
    check("snap_y1", 32'(mbuf[3]), 32'hFF);
    check("snap_z0", 32'(mbuf[4]), 32'h00);
    check("snap_z1", 32'(mbuf[5]), 32'h01);

    // 4: MB write wrapping 0x3F -> 0x00 (read-only) -> 0x01
    base = stb_total;
    write_bytes(8'h7F, 8'h11, 8'h22, 8'h33, 3);
    check("wrap_stb_cnt", 32'(stb_total - base), 32'h2);
    check("wrap_addr0", 32'(log_addr[base % 16]), 32'h3F);
    check("wrap_data0", 32'(log_data[base % 16]), 32'h11);
    check("wrap_addr1", 32'(log_addr[(base + 1) % 16]), 32'h01);
    check("wrap_data1", 32'(log_data[(base + 1) % 16]), 32'h33);
    read1(8'h80, rd);
    check("wrap_devid", 32'(rd), 32'hE5);
    read1(8'hBF, rd);
    check("wrap_rd_3f", 32'(rd), 32'h11);
    read1(8'h81, rd);
    check("wrap_rd_01", 32'(rd), 32'h33);

    // 5: abort a write after 5 data bits
    base = stb_total;
    csn_low();
    spi_bits(8'h31, 8, 1'b0, dummy);
    spi_bits(8'h0B, 5, 1'b0, dummy);
    csn_high();
    check("abort_no_stb", 32'(stb_total - base), 32'h0);
    read1(8'hB1, rd);
    check("abort_rd_31", 32'(rd), 32'h00);
    base = stb_total;
    write_bytes(8'h31, 8'h0B, 8'h00, 8'h00, 1);
    check("post_abort_stb", 32'(stb_total - base), 32'h1);
    read1(8'hB1, rd);
    check("post_abort_rd", 32'(rd), 32'h0B);

    // 6: reset during bit 3 of a read of 0x2D (holds 0x08)
    csn_low();
    spi_bits(8'hAD, 8, 1'b0, dummy);
    spi_bits(8'hFF, 3, 1'b0, rd);
    check("mid_rd_bits", 32'(rd[7:5]), 32'h0);
    check("mid_oe_on", 32'(oSDIO_OE), 32'h1);
    @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    check("rst_oe_off", 32'(oSDIO_OE), 32'h0);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    oe_hits = 0;
    spi_bits(8'hFF, 5, 1'b1, dummy);
    check("rst_stay_idle", 32'(oe_hits), 32'h0);
    csn_high();
    read1(8'hAD, rd);
    check("rst_cleared_2d", 32'(rd), 32'h00);
    read1(8'h80, rd);
    check("rst_devid", 32'(rd), 32'hE5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gsensor_spi_responder.md
Name: gsensor_spi_responder

Overview:
- Synthesizable 3-wire SPI responder that stands in for the ADXL345-style accelerometer. It answers the existing `spi_ee_config` initiator over `GSENSOR_*` or Arduino header pins.
- Enables loopback testing of the G-sensor path without the real device.
- Holds a 64x8 register file: fixed DEVID, R/W config registers, and read-only axis data snapshotted from parallel inputs.
- Runs entirely in the `MAX10_CLK1_50` domain by oversampling SCLK, CS_N and SDIO.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on each SPI input.
- DEVID, 8'hE5, value returned at address 0x00.
- ADDR_W, 6, register address width (64 entries).

Ports:
- iCLK  in  1  system clock, 50 MHz (`MAX10_CLK1_50`).
- iRST  in  1  synchronous reset, active-high.
- iSPI_CSN  in  1  chip select, active-low.
- iSPI_CLK  in  1  SPI clock, mode 3 (idle high), ≤2 MHz.
- iSDIO  in  1  SDIO pin input.
- oSDIO  out  1  SDIO drive value.
- oSDIO_OE  out  1  SDIO output enable; the top level builds the tristate.
- iDATA_X  in  16  X axis sample, two's complement.
- iDATA_Y  in  16  Y axis sample, two's complement.
- iDATA_Z  in  16  Z axis sample, two's complement.
- oWR_STB  out  1  one-cycle pulse per committed register write.
- oWR_ADDR  out  6  address of the committed write.
- oWR_DATA  out  8  data of the committed write.

Behaviour:

Reset and input path
- iRST=1 (sync): state IDLE, all R/W regs 0x00.
- Reset values of outputs: oSDIO=1, oSDIO_OE=0, oWR_STB=0, oWR_ADDR=0, oWR_DATA=0.
- Inputs pass through SYNC_STAGES flops, then one edge-detect flop.
- Pin-to-action latency is SYNC_STAGES+1 iCLK cycles (3 by default).
- Minimum SCLK half-period is 6 iCLK cycles.

Frame format
- MSB first.
- Byte 0 is the command: bit7 R/W (1=read), bit6 MB (multi-byte), bits5:0 start address.
- Responder samples on detected SCLK rise and changes oSDIO on detected SCLK fall.

State machine: IDLE -> CMD -> {WDATA | RDATA}
- IDLE: on CSN fall, capture iDATA_X/Y/Z into a snapshot; clear bit counter; go to CMD.
- CMD: shift 8 bits. On the 8th rise, latch R/W, MB and addr. Go to RDATA if R/W=1, else WDATA.
- RDATA, first byte: on the 8th CMD rise, load the read shifter with reg[addr].
  - On the next SCLK fall: oSDIO_OE=1, oSDIO=bit7.
  - Each following fall shifts out the next bit.
- RDATA, subsequent bytes: on the 8th rise of a data byte, update addr, then reload the shifter from the new addr (or the same addr).
- WDATA: shift 8 bits. On the 8th rise, commit the byte the next iCLK cycle:
  - reg[addr] <= byte;
  - oWR_STB=1 for exactly one cycle, with oWR_ADDR/oWR_DATA valid in that cycle;
  - then update addr.

Address update
- MB=1: addr+1, wrapping 0x3F -> 0x00.
- MB=0: addr unchanged, so repeated bytes re-read or re-write the same register.

Register map
- 0x00: DEVID, read-only.
- 0x32/0x33: X low/high from the snapshot.
- 0x34/0x35: Y low/high from the snapshot.
- 0x36/0x37: Z low/high from the snapshot.
- All other addresses: R/W, reset 0x00.
- Snapshot is held for the whole frame, so multi-byte reads are coherent even if iDATA_* changes mid-frame.

Boundary conditions
- Write to a read-only address: storage unchanged, no oWR_STB. Address still advances under MB.
- Detected CSN rise in any state: go to IDLE the same cycle, oSDIO_OE=0, oSDIO=1.
  - A partial byte is discarded, with no write and no strobe.
  - A byte whose 8th rise is detected in the same cycle as the CSN rise is committed; commit takes priority.
- SCLK edges while CSN=1: ignored.
- CSN fall while not IDLE (glitch without a preceding rise): restart the frame in CMD.
- iRST mid-frame: state machine goes to IDLE, registers are cleared, SDIO is released.
  - If CSN is still low when reset deasserts, stay in IDLE until the next CSN fall.

Decomposition:
- Package `gsensor_spi_pkg` holds:
  - register address constants: ADDR_DEVID, ADDR_DATAX0..ADDR_DATAZ1, ADDR_BW_RATE=0x2C, ADDR_POWER_CTL=0x2D, ADDR_DATA_FORMAT=0x31;
  - DEVID default;
  - state encoding for IDLE/CMD/WDATA/RDATA;
  - command bit positions.
- One sub-module, `spi_sync_edge`: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instantiate it for CSN and SCLK, and use its synchronized output for SDIO.

Test Plan:
1. DEVID read: command 0x80, 8 clocks at 2 MHz -> SDIO returns 0xE5; OE high only during the data byte; no oWR_STB.
2. Write then read back: write 0x2D=0x08 with command 0x2D -> oWR_STB pulses once with addr 0x2D, data 0x08; then read command 0xAD -> 0x08.
3. Multi-byte snapshot read: X=0x1234, Y=0xFF80, Z=0x0100; command 0xF2 with 6 bytes; change iDATA_X to 0xAAAA after byte 2 -> bytes 0x34,0x12,0x80,0xFF,0x00,0x01.
4. Wrap and read-only: MB write from 0x3F with 0x11,0x22,0x33 -> strobes only for 0x3F=0x11 and 0x01=0x33; 0x00 still reads 0xE5.
5. Abort: CSN rises after 5 data bits of a write to 0x31 -> no strobe, 0x31 unchanged; the next frame parses normally.
6. Reset mid-read: assert iRST during bit 3 of a read -> oSDIO_OE=0 the next cycle, regs read 0x00 after reset, and the next CSN frame works.
